// File: rtl/zeroriscy_mmult_pack.sv
// Requantises mmult int16 lane pairs to int8 and packs two input words per 32-bit output,
// buffered in a small FIFO. Define ZERORISCY_PACK_RELU_EN to clamp negative lanes to zero.
module zeroriscy_mmult_pack #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  input  logic [3:0]  cfg_shift_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  input  logic        out_ready_i,
  output logic        sat_o,
  input  logic        sat_clr_i,
  output logic        idle_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  // Returns {saturated, int8}; ReLU clamping never counts as saturation.
  function automatic logic [8:0] lane_conv(input logic [15:0] lane, input logic [3:0] sh);
    logic signed [16:0] ext;
    logic signed [16:0] bias;
    logic signed [16:0] val;
    logic               sat;
    logic [7:0]         b;
    ext  = signed'({lane[15], lane});
    bias = (sh != 4'd0) ? (17'sd1 <<< (sh - 4'd1)) : 17'sd0;
    val  = (ext + bias) >>> sh;
`ifdef ZERORISCY_PACK_RELU_EN
    if (val < 17'sd0) begin
      b   = 8'h00;
      sat = 1'b0;
    end else if (val > 17'sd127) begin
      b   = 8'h7f;
      sat = 1'b1;
    end else begin
      b   = val[7:0];
      sat = 1'b0;
    end
`else
    if (val > 17'sd127) begin
      b   = 8'h7f;
      sat = 1'b1;
    end else if (val < -17'sd128) begin
      b   = 8'h80;
      sat = 1'b1;
    end else begin
      b   = val[7:0];
      sat = 1'b0;
    end
`endif
    return {sat, b};
  endfunction

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     hold_q, hold_d;
  logic            half_q, half_d;
  logic            flush_pend_q, flush_pend_d;
  logic            sat_q, sat_d;

  logic        full, accept, push, pop, flush_push;
  logic [8:0]  conv0, conv1;
  logic [31:0] push_data;

  always_comb begin
    full        = (count_q == CntW'(FIFO_DEPTH));
    in_ready_o  = ~flush_pend_q & (~half_q | ~full);
    accept      = in_valid_i & in_ready_o;
    conv0       = lane_conv(in_data_i[31:16], cfg_shift_i);
    conv1       = lane_conv(in_data_i[15:0], cfg_shift_i);
    flush_push  = flush_pend_q & half_q & ~full;
    push        = (accept & half_q) | flush_push;
    push_data   = flush_push ? {hold_q, 16'h0000} : {hold_q, conv0[7:0], conv1[7:0]};
    out_valid_o = (count_q != '0);
    pop         = out_valid_o & out_ready_i;
    out_data_o  = mem_q[rptr_q];
    sat_o       = sat_q;
    idle_o      = ~half_q & ~flush_pend_q & (count_q == '0);
  end

  always_comb begin
    half_d = half_q;
    if (accept)          half_d = ~half_q;
    else if (flush_push) half_d = 1'b0;

    hold_d = (accept & ~half_q) ? {conv0[7:0], conv1[7:0]} : hold_q;

    // A flush raised alongside an accept is evaluated against the updated half flag next cycle.
    flush_pend_d = flush_pend_q;
    if (flush_i)                                flush_pend_d = 1'b1;
    else if (flush_pend_q & (~half_q | ~full))  flush_pend_d = 1'b0;

    sat_d = sat_q;
    if (accept & (conv0[8] | conv1[8])) sat_d = 1'b1;
    else if (sat_clr_i)                 sat_d = 1'b0;

    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PtrW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      half_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      half_q       <= half_d;
      flush_pend_q <= flush_pend_d;
      sat_q        <= sat_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: tb/tb_zeroriscy_mmult_pack.sv
// Scoreboard bench for zeroriscy_mmult_pack; expected words are queued at issue and
// checked by a monitor when the FIFO head is popped.
module tb_zeroriscy_mmult_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o;
  logic [3:0]  cfg_shift_i;
  logic        flush_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_ready_i;
  logic        sat_o;
  logic        sat_clr_i;
  logic        idle_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        rnd_done;

  always #5 clk = ~clk;

  zeroriscy_mmult_pack #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .cfg_shift_i (cfg_shift_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .sat_o       (sat_o),
    .sat_clr_i   (sat_clr_i),
    .idle_o      (idle_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: the head is consumed on the coming posedge when valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", out_data_o, e);
        end
      end
    end
  end

  // Caller sits #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] sh);
    int   n;
    logic ok;
    in_valid_i  = 1'b1;
    in_data_i   = d;
    cfg_shift_i = sh;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready_o=0 expected 1 for word %h", d);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!idle_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check({name, "_idle"}, {31'd0, idle_o}, 32'd1);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    cfg_shift_i = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    sat_clr_i   = 1'b0;
    rnd_done    = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_sat", {31'd0, sat_o}, 32'd0);
    check("rst_idle", {31'd0, idle_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Test 1: shift 0, saturation both ways
    out_ready_i = 1'b1;
`ifdef ZERORISCY_PACK_RELU_EN
    exp_q.push_back(32'h05007F00);
`else
    exp_q.push_back(32'h05FE7F80);
`endif
    send(32'h0005FFFE, 4'd0);
    check("t1_no_sat_first", {31'd0, sat_o}, 32'd0);
    send(32'h0100FF00, 4'd0);
    check("t1_latency_valid", {31'd0, out_valid_o}, 32'd1);
    check("t1_sat", {31'd0, sat_o}, 32'd1);
    wait_idle("t1");
    sat_clr_i = 1'b1;
    tick();
    sat_clr_i = 1'b0;
    check("t1_sat_clr", {31'd0, sat_o}, 32'd0);
    // set wins over clear in the same cycle
    exp_q.push_back(32'h7F000000);
    sat_clr_i = 1'b1;
    send(32'h7FFF0000, 4'd0);
    sat_clr_i = 1'b0;
    check("t1_set_wins", {31'd0, sat_o}, 32'd1);
    send(32'h00000000, 4'd0);
    wait_idle("t1b");
    sat_clr_i = 1'b1;
    tick();
    sat_clr_i = 1'b0;
    check("t1_sat_clr2", {31'd0, sat_o}, 32'd0);

    // Test 2: shift 4 with round-half-up
    exp_q.push_back(32'h02FF0001);
    send(32'h0018FFE8, 4'd4);
    send(32'h00070008, 4'd4);
    wait_idle("t2");
    check("t2_sat", {31'd0, sat_o}, 32'd0);

    // Test 3: flush of a half word, then an idle flush
    exp_q.push_back(32'h03040000);
    send(32'h00030004, 4'd0);
    check("t3_not_idle", {31'd0, idle_o}, 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t3_ready_during_flush", {31'd0, in_ready_o}, 32'd0);
    wait_idle("t3");
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    tick();
    check("t3_second_flush_idle", {31'd0, idle_o}, 32'd1);
    check("t3_second_flush_none", {31'd0, out_valid_o}, 32'd0);

    // Test 4: back-pressure with FIFO full and a held half word
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++)
      exp_q.push_back({8'(2*k), 8'(2*k+16), 8'(2*k+1), 8'(2*k+17)});
    for (int i = 0; i < 9; i++) send({16'(i), 16'(i + 16)}, 4'd0);
    tick();
    check("t4_full_not_ready", {31'd0, in_ready_o}, 32'd0);
    check("t4_full_valid", {31'd0, out_valid_o}, 32'd1);
    out_ready_i = 1'b1;
    @(negedge clk);
    check("t4_no_bypass", {31'd0, in_ready_o}, 32'd0);
    tick();
    check("t4_ready_after_pop", {31'd0, in_ready_o}, 32'd1);
    send({16'd9, 16'd25}, 4'd0);
    wait_idle("t4");

    // Test 5: pointer wrap under random consumer stalls
    for (int k = 0; k < 12; k++)
      exp_q.push_back({8'(6*k), 8'(8'hFF - 8'(2*k)), 8'(6*k+3), 8'(8'hFE - 8'(2*k))});
    fork
      begin
        for (int j = 0; j < 24; j++) send({16'(3*j), 16'(16'hFFFF - 16'(j))}, 4'd0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready_i = 1'b1;
    wait_idle("t5");

    // Test 6: async reset mid-operation
    out_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) send({16'h0011, 16'h0022}, 4'd0);
    check("t6_pre_busy", {31'd0, idle_o}, 32'd0);
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("t6_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("t6_rst_idle", {31'd0, idle_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    out_ready_i = 1'b1;
    exp_q.push_back(32'h01020304);
    send(32'h00010002, 4'd0);
    send(32'h00030004, 4'd0);
    wait_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zeroriscy_mmult_pack.md
Name: zeroriscy_mmult_pack

Overview:
Downstream consumer of the mmult IP8 result word. Each input word carries two signed 16-bit partial sums: lane0 in [31:16] and lane1 in [15:0].
- Each lane is requantised to int8 by an arithmetic right shift with round-half-up and saturation.
- Two consecutive input words are packed into one 32-bit output word.
- Packed words are buffered in a small FIFO that the store path drains with a valid/ready handshake.
- Decouples the fixed-latency mmult pipeline from memory write-back.

Parameters:
FIFO_DEPTH  4  output FIFO entries; power of two, >= 2.

Ports:
clk          in   1   clock.
rst          in   1   reset; asynchronous, active-high.
in_valid_i   in   1   in_data_i valid.
in_data_i    in   32  {lane0[15:0], lane1[15:0]}, signed.
in_ready_o   out  1   input accepted on a cycle where in_valid_i & in_ready_o.
cfg_shift_i  in   4   right-shift amount 0..15; sampled per accepted word.
flush_i      in   1   1-cycle pulse: emit any half-filled word, zero-padded.
out_valid_o  out  1   FIFO head valid.
out_data_o   out  32  packed int8 word, FIFO head.
out_ready_i  in   1   consumer pops the head when out_valid_o & out_ready_i.
sat_o        out  1   sticky: at least one lane saturated.
sat_clr_i    in   1   clears sat_o.
idle_o       out  1   no hold data, no flush pending, FIFO empty.

Behaviour:
Reset (async, any time, including mid-operation):
- FIFO emptied; half=0, flush_pend=0, hold=0.
- out_valid_o=0, in_ready_o=1, sat_o=0, idle_o=1.

Lane conversion (combinational, at accept):
- Sign-extend the lane to 17 bits.
- If shift>0, add 1<<(shift-1), then arithmetic shift right by shift.
- Saturate to [-128,127].
- Saturation sets sat_o on the next edge. If sat_clr_i is asserted in the same cycle as a saturation event, set wins.

Packing (half flag):
- Accept with half=0: hold[15:0] <= {b0,b1}; half <= 1.
- Accept with half=1: push {hold, b0, b1} into the FIFO; half <= 0.
- Byte order: first word's lane0 in [31:24], lane1 in [23:16]; second word's lane0 in [15:8], lane1 in [7:0].

Handshake and latency:
- in_ready_o = ~flush_pend & (~half | ~full).
- Completing word accepted at edge N → out_valid_o high from cycle N+1 if the FIFO was empty.
- No bypass path. When the FIFO is full, a same-cycle pop does not re-enable in_ready_o until the next cycle.

FIFO:
- Registered read/write pointers with an occupancy count 0..FIFO_DEPTH.
- Simultaneous push and pop: count unchanged; data order preserved.
- Pointers wrap modulo FIFO_DEPTH.
- out_data_o is driven directly from the head entry.
- A pop while empty is impossible because out_valid_o=0.

Flush:
- flush_i sets flush_pend.
- flush_pend & half & ~full: push {hold, 16'h0000}; half <= 0; flush_pend <= 0.
- flush_pend & ~half: clear flush_pend with no push.
- flush_pend & half & full: hold off until a slot frees.
- flush_i in the same cycle as an accept: the accept is processed first, then the flush rules apply from the next cycle.

idle_o = ~half & ~flush_pend & (count==0).

Optional Feature:
ZERORISCY_PACK_RELU_EN
- Defined: after rounding and shifting, negative values clamp to 0 before saturation. Values clamped by ReLU do not set sat_o; only overflow above 127 does.
- Undefined: signed saturation to [-128,127] as above.

Test Plan:
1. shift=0, inputs 0x0005FFFE then 0x0100FF00 → out 0x05FE7F80, sat_o=1. With ZERORISCY_PACK_RELU_EN defined → 0x05007F00.
2. shift=4, inputs 0x0018FFE8 then 0x00070008 → bytes 02, FF (rounding, -24→-1), 00, 01 → out 0x02FF0001, sat_o=0.
3. Accept 0x00030004 (shift 0), then pulse flush_i → out 0x03040000 one word only. A second flush with half=0 pushes nothing; idle_o returns to 1.
4. FIFO_DEPTH=4, out_ready_i=0, stream 10 words:
   - 4 entries fill, the 9th word goes into hold, then in_ready_o=0.
   - Raise out_ready_i: 4 words pop in order, the 10th word is accepted and completes the 5th packed word.
5. Push and pop in the same cycle with count=2 → count stays 2, data order intact. Pointer wrap exercised over 12 words with random out_ready_i.
6. Assert rst while half=1 and the FIFO holds 3 words → out_valid_o=0, in_ready_o=1, idle_o=1 immediately. The next pair of inputs produces a fresh word with no stale bytes.
